// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter.
//   state_e      : controller state encoding (idle / busy / done)
//   DataWidth    : operand and result width
//   Div0Quotient : quotient reported when the divisor is zero
package div_arbiter_pkg;

    localparam int unsigned DataWidth = 32;
    localparam logic [DataWidth-1:0] Div0Quotient = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/div_arbiter_divide.sv
// Combinational unsigned divide unit shared by both requesters.
//   a_i         : dividend
//   b_i         : divisor
//   quotient_o  : a_i / b_i (0 when b_i is zero; callers override that case)
//   remainder_o : a_i % b_i (0 when b_i is zero)
module div_arbiter_divide
    import div_arbiter_pkg::*;
(
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic [DataWidth-1:0] quotient_o,
    output logic [DataWidth-1:0] remainder_o
);

    always_comb begin
        quotient_o  = '0;
        remainder_o = '0;
        if (b_i != '0) begin
            quotient_o  = a_i / b_i;
            remainder_o = a_i % b_i;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter in front of one shared combinational divider.
//   clock, clear             : rising-edge clock, async active-low reset
//   req0_*/req1_*            : valid/ready operand handshakes, A = dividend, B = divisor
//   rsp_valid/rsp_ready      : result handshake
//   rsp_id                   : requester owning the result
//   rsp_quotient/_remainder  : registered results; rsp_div0 flags a zero divisor
//   busy                     : high whenever a job is in flight or awaiting pickup
// The divider is given LATENCY cycles to settle before its outputs are sampled.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DataWidth-1:0] req0_a,
    input  logic [DataWidth-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DataWidth-1:0] req1_a,
    input  logic [DataWidth-1:0] req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DataWidth-1:0] rsp_quotient,
    output logic [DataWidth-1:0] rsp_remainder,
    output logic                 rsp_div0,
    output logic                 busy
);

    localparam logic [3:0] CountLoad = 4'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [3:0]           count_q;
    logic [DataWidth-1:0] a_q, b_q;
    logic                 id_q;
    logic                 last_q;
    logic                 grant_valid;
    logic                 grant_id;
    logic                 accept;
    logic [DataWidth-1:0] div_quotient, div_remainder;

    // Both valid: the one not granted last wins. Otherwise the lone valid one wins.
    // last_q only moves on a real grant, so dropping valid never costs priority.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        accept      = (state_q == StIdle) & grant_valid;
        req0_ready  = accept & ~grant_id;
        req1_ready  = accept & grant_id;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_valid) state_d = StBusy;
            StBusy:  if (count_q == 4'd0) state_d = StDone;
            StDone:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q       <= 4'd0;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            last_q        <= 1'b1;
            rsp_id        <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= grant_id ? req1_a : req0_a;
                b_q     <= grant_id ? req1_b : req0_b;
                id_q    <= grant_id;
                last_q  <= grant_id;
                count_q <= CountLoad;
            end
            if (state_q == StBusy) begin
                if (count_q == 4'd0) begin
                    rsp_id <= id_q;
                    if (b_q == '0) begin
                        rsp_quotient  <= Div0Quotient;
                        rsp_remainder <= a_q;
                        rsp_div0      <= 1'b1;
                    end else begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_div0      <= 1'b0;
                    end
                end else begin
                    count_q <= count_q - 4'd1;
                end
            end
        end
    end

    div_arbiter_divide u_divide (
        .a_i         (a_q),
        .b_i         (b_q),
        .quotient_o  (div_quotient),
        .remainder_o (div_remainder)
    );

    assign rsp_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule
